puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Clocked controller that sits directly upstream and downstream of puf_parallel_subblock.
- Drives the subblock's challenge, enable and reset, then collects its out/done result.
- On start it applies RESP_BITS consecutive challenges, derived from a base challenge, one race per challenge.
- Assembles the race results into a RESP_BITS-wide response word and delivers it over a valid/ready handshake.

Parameters:
- RESP_BITS, 32, number of challenges per response (1..256).
- SETTLE_CYCLES, 4, cycles sub_reset is held high before each race (>=1).
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for sub_done per race (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a response; honoured only in IDLE.
- base_challenge  in  8  first challenge of the sequence; sampled when start is accepted.
- sub_out  in  1  race result from the subblock; asynchronous to clock.
- sub_done  in  1  race-finished flag from the subblock; asynchronous to clock.
- sub_challenge  out  8  challenge applied to the subblock.
- sub_enable  out  32  ring-oscillator enables.
- sub_reset  out  1  active-high reset to the subblock's counters and arbiter.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer accepts the response.
- response  out  RESP_BITS  collected response word.
- timeout_err  out  1  sticky flag: at least one race in this response timed out.

Behaviour:
- Reset (async assert, sync deassert) values:
  - State is IDLE.
  - sub_reset=1, sub_enable=0, sub_challenge=0.
  - busy=0, resp_valid=0, response=0, timeout_err=0.
  - All counters and synchronizer flops are 0.
- Synchronization: sub_out and sub_done each pass through a 2-flop synchronizer, giving out_s and done_s. No other logic samples the raw inputs.
- IDLE:
  - sub_reset=1, sub_enable=0.
  - start=1 does the following: latches chal=base_challenge, sets idx=0, clears timeout_err and response, then goes to CLEAR.
- CLEAR:
  - sub_reset=1, sub_enable=0, sub_challenge=chal.
  - Lasts exactly SETTLE_CYCLES cycles, then goes to RUN.
- RUN:
  - sub_reset=0, sub_enable=32'hFFFF_FFFF, sub_challenge=chal.
  - A timeout counter starts from 0.
  - If done_s=1, go to CAPTURE.
  - Otherwise, once the counter reaches TIMEOUT_CYCLES-1, set timeout_err, force the result bit to 0, and go to NEXT.
  - If done_s and the timeout occur in the same cycle, done_s wins.
- CAPTURE (1 cycle):
  - Writes response[idx]=out_s.
  - sub_enable stays all-ones and sub_reset stays 0.
  - Goes to NEXT.
- NEXT (1 cycle):
  - sub_enable=0, sub_reset=1.
  - If idx==RESP_BITS-1, go to VALID.
  - Otherwise: idx+=1, chal=chal+1 (8-bit wrap, so 8'hFF is followed by 8'h00), go to CLEAR.
- VALID:
  - resp_valid=1; response and timeout_err are held stable.
  - Leaves only on resp_valid & resp_ready, returning to IDLE in the next cycle with resp_valid=0.
  - resp_valid never drops without the handshake.
- Bit order: response[i] is the result of challenge base_challenge+i (mod 256).
- start outside IDLE is ignored with no queuing, including start in the same cycle as the handshake.
- Reset asserted mid-operation returns immediately to reset values. Any partial response is discarded.
- Latency with no backpressure, from accepting start to resp_valid, where Ri is the number of RUN cycles for race i:
  - sum over races of (SETTLE_CYCLES + Ri + 2), minus 1 for each timed-out race (those skip CAPTURE).

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each challenge is raced 3 times, each race preceded by its own CLEAR.
  - The bit written is the majority of the three results. A timed-out race contributes 0.
  - A 2-bit repeat counter and a 2-bit ones counter are added.
  - chal and idx advance only after the third race.
- Undefined: one race per challenge, exactly as described above.
- The ports are identical in both builds.

Decomposition:
- Package puf_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, CLEAR, RUN, CAPTURE, NEXT, VALID};
  - localparam CHALLENGE_W=8 and NUM_RO=32.
- Sub-module puf_sync2: parameterless 1-bit 2-flop synchronizer with clock/reset. It is instantiated twice.

Test Plan:
- Basic response: RESP_BITS=4, base_challenge=8'h10. The subblock model returns out=1,0,1,1 with done raised 20 cycles after enable.
  - sub_challenge steps through 10,11,12,13.
  - response=4'b1101, timeout_err=0.
  - busy is high from the cycle after start until the handshake.
- Challenge wrap: base_challenge=8'hFE, RESP_BITS=4 -> sub_challenge sequence is FE, FF, 00, 01.
- Timeout: TIMEOUT_CYCLES=50. The model never raises done for challenge index 2.
  - response[2]=0 and timeout_err=1.
  - The other bits match the model.
  - timeout_err clears on the next accepted start.
- Backpressure: resp_ready held 0 for 30 cycles after resp_valid.
  - resp_valid and response stay stable throughout.
  - start pulses during the stall are ignored.
  - After ready, resp_valid=0 next cycle and the block returns to IDLE.
- Reset mid-RUN: drive reset low during race 1.
  - Immediately: sub_reset=1, sub_enable=0, busy=0, response=0.
  - A fresh start then completes normally.
- PUF_MAJORITY_VOTE_EN: the model returns 1,0,1 for challenge 0 and 0,0,1 for challenge 1.
  - response[1:0]=2'b01.
  - 6 CLEAR phases are observed.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and widths for the PUF challenge sequencer
package puf_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, NEXT, VALID} seq_state_t;
    localparam int CHALLENGE_W = 8;
    localparam int NUM_RO = 32;
endpackage

// File: rtl/puf_challenge_sequencer_sync2.sv
// puf_sync2: 1-bit two-flop synchronizer for the subblock's asynchronous outputs
module puf_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clock or negedge reset)
        if (!reset) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
endmodule

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: races RESP_BITS consecutive challenges and returns the response word
// PUF_MAJORITY_VOTE_EN: race each challenge three times and keep the majority bit
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int RESP_BITS      = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CHALLENGE_W-1:0] base_challenge,
    input  logic                   sub_out,
    input  logic                   sub_done,
    output logic [CHALLENGE_W-1:0] sub_challenge,
    output logic [NUM_RO-1:0]      sub_enable,
    output logic                   sub_reset,
    output logic                   busy,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [RESP_BITS-1:0]   response,
    output logic                   timeout_err
);
    localparam int IW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
    seq_state_t state, state_n;
    logic [CHALLENGE_W-1:0] chal, chal_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0] cnt, cnt_n;
    logic [RESP_BITS-1:0] resp_n;
    logic terr_n, out_s, done_s, racing;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] rep, rep_n, ones, ones_n;
`endif

    puf_sync2 u_sync_out  (.clock(clock), .reset(reset), .d(sub_out),  .q(out_s));
    puf_sync2 u_sync_done (.clock(clock), .reset(reset), .d(sub_done), .q(done_s));

    assign racing        = state == RUN || state == CAPTURE;
    assign sub_challenge = chal;
    assign sub_enable    = racing ? {NUM_RO{1'b1}} : '0;
    assign sub_reset     = !racing;
    assign busy          = state != IDLE;
    assign resp_valid    = state == VALID;

    always_comb begin
        state_n = state;
        chal_n  = chal;
        idx_n   = idx;
        cnt_n   = cnt;
        resp_n  = response;
        terr_n  = timeout_err;
`ifdef PUF_MAJORITY_VOTE_EN
        rep_n   = rep;
        ones_n  = ones;
`endif
        case (state)
            IDLE: if (start) begin
                chal_n  = base_challenge;
                idx_n   = '0;
                cnt_n   = '0;
                resp_n  = '0;
                terr_n  = 1'b0;
                state_n = CLEAR;
`ifdef PUF_MAJORITY_VOTE_EN
                rep_n   = '0;
                ones_n  = '0;
`endif
            end
            CLEAR: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(SETTLE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_n = cnt + 32'd1;
                if (done_s) begin
                    cnt_n   = '0;
                    state_n = CAPTURE;
                end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    cnt_n   = '0;
                    terr_n  = 1'b1;
                    state_n = NEXT;
`ifndef PUF_MAJORITY_VOTE_EN
                    resp_n[idx] = 1'b0;
`endif
                end
            end
            CAPTURE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                ones_n = ones + {1'b0, out_s};
`else
                resp_n[idx] = out_s;
`endif
                state_n = NEXT;
            end
            NEXT: begin
                state_n = CLEAR;
`ifdef PUF_MAJORITY_VOTE_EN
                rep_n = rep + 2'd1;
                if (rep == 2'd2) begin
                    rep_n       = '0;
                    ones_n      = '0;
                    resp_n[idx] = ones[1];
`endif
                    if (idx == IW'(RESP_BITS - 1)) state_n = VALID;
                    else begin
                        idx_n  = idx + 1'b1;
                        chal_n = chal + 1'b1;
                    end
`ifdef PUF_MAJORITY_VOTE_EN
                end
`endif
            end
            VALID: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state       <= IDLE;
            chal        <= '0;
            idx         <= '0;
            cnt         <= '0;
            response    <= '0;
            timeout_err <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            rep         <= '0;
            ones        <= '0;
`endif
        end else begin
            state       <= state_n;
            chal        <= chal_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            response    <= resp_n;
            timeout_err <= terr_n;
`ifdef PUF_MAJORITY_VOTE_EN
            rep         <= rep_n;
            ones        <= ones_n;
`endif
        end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer: scoreboard bench with a behavioural PUF subblock model
module tb_puf_challenge_sequencer;
    localparam int RB = 4;
    localparam int ST = 4;
    localparam int TO = 50;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif

    logic clock = 0, reset = 0, start = 0, resp_ready = 1, sub_out = 0, sub_done = 0;
    logic [7:0] base_challenge = 0;
    logic [7:0] sub_challenge;
    logic [31:0] sub_enable;
    logic sub_reset, busy, resp_valid, timeout_err;
    logic [RB-1:0] response;

    puf_challenge_sequencer #(.RESP_BITS(RB), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .base_challenge(base_challenge),
        .sub_out(sub_out), .sub_done(sub_done), .sub_challenge(sub_challenge),
        .sub_enable(sub_enable), .sub_reset(sub_reset), .busy(busy), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .response(response), .timeout_err(timeout_err));

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    logic [4:0] exp_q[$];
    logic [7:0] chal_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // subblock model: done rises 20 enabled cycles into a race unless that index is blocked
    logic [7:0] base_m = 0;
    logic [3:0] out_pat = 0;
    logic [11:0] maj_pat = 0;
    logic use_maj = 0;
    int never_idx = -1;
    int en_cnt = 0, race_n = 0;
    logic [1:0] ci;
    assign ci = 2'(sub_challenge - base_m);
    always @(posedge clock) begin
        if (!reset) race_n <= 0;
        if (sub_reset) begin
            en_cnt   <= 0;
            sub_done <= 1'b0;
        end else if (sub_enable == '1) begin
            en_cnt <= en_cnt + 1;
            if (en_cnt == 19 && int'(ci) != never_idx) begin
                sub_done <= 1'b1;
                sub_out  <= use_maj ? maj_pat[race_n] : out_pat[ci];
                race_n   <= race_n + 1;
            end
        end
    end

    logic prev_en = 0;
    logic [4:0] e;
    always @(negedge clock) begin
        if (sub_enable == '1 && !prev_en) begin
            if (chal_q.size() == 0) chk("unexpected_race", 1, 0);
            else chk("sub_challenge", sub_challenge, chal_q.pop_front());
        end
        prev_en = sub_enable == '1;
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("response", response, e[3:0]);
                chk("timeout_err", timeout_err, e[4]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [7:0] b, input logic [3:0] pat, input int nv,
                          input logic [3:0] er, input logic et);
        base_m    = b;
        out_pat   = pat;
        never_idx = nv;
        exp_q.push_back({et, er});
        for (int i = 0; i < RB; i++)
            for (int r = 0; r < REP; r++) chal_q.push_back(8'(b + 8'(i)));
        base_challenge = b;
        start = 1;
        tick();
        start = 0;
        base_challenge = 8'h55;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!resp_valid && n < 5000) begin
            tick();
            n++;
        end
        if (!resp_valid) chk("valid_wait_expired", 0, 1);
        chk("busy_at_valid", busy, 1);
    endtask

    task automatic finish_hs();
        tick();
        chk("valid_drop", resp_valid, 0);
        chk("idle_after_hs", busy, 0);
    endtask

    initial begin
        logic [3:0] hold;
        logic stable;
        int n;
        #1;
        chk("rst_sub_reset", sub_reset, 1);
        chk("rst_sub_enable", sub_enable, 0);
        chk("rst_sub_challenge", sub_challenge, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_response", response, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        tick();
        reset = 1;
        tick();

        launch(8'h10, 4'b1101, -1, 4'b1101, 1'b0);
        wait_valid();
        finish_hs();

        launch(8'hFE, 4'b0110, -1, 4'b0110, 1'b0);
        wait_valid();
        finish_hs();

        launch(8'h20, 4'b1111, 2, 4'b1011, 1'b1);
        wait_valid();
        finish_hs();

        launch(8'h30, 4'b0011, -1, 4'b0011, 1'b0);
        chk("timeout_err_cleared", timeout_err, 0);
        wait_valid();
        finish_hs();

        resp_ready = 0;
        launch(8'h40, 4'b1010, -1, 4'b1010, 1'b0);
        wait_valid();
        hold = response;
        stable = 1;
        for (int i = 0; i < 30; i++) begin
            start = i == 10;
            tick();
            if (!resp_valid || response !== hold || !busy) stable = 0;
        end
        start = 0;
        chk("stall_stable", stable, 1);
        chk("stall_response", hold, 4'b1010);
        resp_ready = 1;
        start = 1;
        tick();
        start = 0;
        chk("bp_valid_drop", resp_valid, 0);
        chk("bp_idle", busy, 0);
        tick();
        chk("start_at_hs_ignored", busy, 0);

        launch(8'h50, 4'b1111, -1, 4'b1111, 1'b0);
        n = 0;
        while (!(sub_enable == '1 && sub_challenge == 8'h51) && n < 2000) begin
            tick();
            n++;
        end
        chk("reach_race1", sub_challenge, 8'h51);
        reset = 0;
        #1;
        chk("midrst_sub_reset", sub_reset, 1);
        chk("midrst_sub_enable", sub_enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_response", response, 0);
        exp_q.delete();
        chal_q.delete();
        tick();
        reset = 1;
        tick();
        launch(8'h60, 4'b1001, -1, 4'b1001, 1'b0);
        wait_valid();
        finish_hs();

`ifdef PUF_MAJORITY_VOTE_EN
        reset = 0;
        tick();
        reset = 1;
        tick();
        use_maj = 1;
        maj_pat = 12'b000_011_100_101;
        launch(8'h00, 4'b0000, -1, 4'b0101, 1'b0);
        wait_valid();
        finish_hs();
        use_maj = 0;
`endif

        chk("exp_q_drained", 64'(exp_q.size()), 0);
        chk("chal_q_drained", 64'(chal_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
